// File: rtl/ball_pkg.sv
// Shared constants and state encoding for the bouncing-ball mover.
// Positions and speeds are fixed point with FRAC_BITS fraction bits (1 px = 64).
package ball_pkg;

  localparam int FRAC_BITS    = 6;
  localparam int POS_W        = 18;
  localparam int PIX_W        = 11;

  localparam int GRAVITY      = 8;
  localparam int MAX_Y_SPEED  = 512;
  localparam int X_SPEED      = 64;
  localparam int BOUNCE_SPEED = 384;
  localparam int X_MAX        = 614;
  localparam int Y_FLOOR      = 414;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    PAUSED  = 2'd2,
    POPPED  = 2'd3
  } state_t;

endpackage

// File: rtl/ball_move.sv
// Ball motion engine: gravity, wall/floor bounces and pop handling, one step per video frame.
// Outputs are registered from the next-state values, so they track the internal state.
module ball_move
  import ball_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             launch,
  input  logic [PIX_W-1:0] initX,
  input  logic [PIX_W-1:0] initY,
  input  logic             dirRight,
  input  logic             pause,
  input  logic             hitRope,
  output logic [PIX_W-1:0] topLeftX,
  output logic [PIX_W-1:0] topLeftY,
  output logic             visible,
  output logic             popped
);

  localparam int EW = POS_W + 1;

  localparam logic signed [POS_W:0] G_STEP     = EW'(GRAVITY);
  localparam logic signed [POS_W:0] Y_VMAX     = EW'(MAX_Y_SPEED);
  localparam logic signed [POS_W:0] X_STEP     = EW'(X_SPEED);
  localparam logic signed [POS_W:0] NEG_BOUNCE = -EW'(BOUNCE_SPEED);
  localparam logic signed [POS_W:0] X_LIM      = EW'(X_MAX * (1 << FRAC_BITS));
  localparam logic signed [POS_W:0] Y_LIM      = EW'(Y_FLOOR * (1 << FRAC_BITS));

  state_t                  state, state_nx;
  logic signed [POS_W-1:0] pos_x, pos_x_nx;
  logic signed [POS_W-1:0] pos_y, pos_y_nx;
  logic signed [POS_W-1:0] y_speed, y_speed_nx;
  logic                    x_dir, x_dir_nx;

  logic signed [POS_W:0]   ys_new, py_new, px_new;

  function automatic logic signed [POS_W:0] widen(input logic signed [POS_W-1:0] v);
    return {v[POS_W-1], v};
  endfunction

  function automatic logic signed [POS_W:0] cap_speed(input logic signed [POS_W:0] v);
    return (v > Y_VMAX) ? Y_VMAX : v;
  endfunction

  // One extra bit of headroom keeps the wall tests exact before clamping.
  always_comb begin
    state_nx   = state;
    pos_x_nx   = pos_x;
    pos_y_nx   = pos_y;
    y_speed_nx = y_speed;
    x_dir_nx   = x_dir;

    ys_new = cap_speed(widen(y_speed) + G_STEP);
    py_new = widen(pos_y) + ys_new;
    px_new = x_dir ? (widen(pos_x) + X_STEP) : (widen(pos_x) - X_STEP);

    case (state)
      IDLE: begin
        if (launch) begin
          pos_x_nx   = {1'b0, initX, {FRAC_BITS{1'b0}}};
          pos_y_nx   = {1'b0, initY, {FRAC_BITS{1'b0}}};
          y_speed_nx = '0;
          x_dir_nx   = dirRight;
          state_nx   = MOVING;
        end
      end
      MOVING: begin
        if (hitRope) begin
          state_nx = POPPED;
        end else if (pause) begin
          state_nx = PAUSED;
        end else if (startOfFrame) begin
          if (px_new < 0) begin
            pos_x_nx = '0;
            x_dir_nx = 1'b1;
          end else if (px_new > X_LIM) begin
            pos_x_nx = X_LIM[POS_W-1:0];
            x_dir_nx = 1'b0;
          end else begin
            pos_x_nx = px_new[POS_W-1:0];
          end

          if ((py_new > Y_LIM) && (ys_new > 0)) begin
            pos_y_nx   = Y_LIM[POS_W-1:0];
            y_speed_nx = NEG_BOUNCE[POS_W-1:0];
          end else if (py_new < 0) begin
            pos_y_nx   = '0;
            y_speed_nx = '0;
          end else begin
            pos_y_nx   = py_new[POS_W-1:0];
            y_speed_nx = ys_new[POS_W-1:0];
          end
        end
      end
      PAUSED: begin
        if (hitRope) begin
          state_nx = POPPED;
        end else if (!pause) begin
          state_nx = MOVING;
        end
      end
      POPPED: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos_x    <= '0;
      pos_y    <= '0;
      y_speed  <= '0;
      x_dir    <= 1'b1;
      topLeftX <= '0;
      topLeftY <= '0;
      visible  <= 1'b0;
      popped   <= 1'b0;
    end else begin
      state    <= state_nx;
      pos_x    <= pos_x_nx;
      pos_y    <= pos_y_nx;
      y_speed  <= y_speed_nx;
      x_dir    <= x_dir_nx;
      topLeftX <= pos_x_nx[FRAC_BITS +: PIX_W];
      topLeftY <= pos_y_nx[FRAC_BITS +: PIX_W];
      visible  <= (state_nx == MOVING) || (state_nx == PAUSED);
      popped   <= (state_nx == POPPED);
    end
  end

endmodule

// File: tb/tb_ball_move.sv
// Bench for ball_move: directed vector table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a pixel-level behavioural model.
module tb_ball_move;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame, launch, dirRight, pause, hitRope;
  logic [10:0] initX, initY;
  logic [10:0] topLeftX, topLeftY;
  logic        visible, popped;

  int vectors = 0;
  int miscompares = 0;

  ball_move dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .launch       (launch),
    .initX        (initX),
    .initY        (initY),
    .dirRight     (dirRight),
    .pause        (pause),
    .hitRope      (hitRope),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .visible      (visible),
    .popped       (popped)
  );

  always #5 clk = ~clk;

  // Model state: ball either absent, alive (moving or frozen) or in its pop cycle.
  int m_x, m_y, m_v;
  bit m_dir, m_alive, m_frozen, m_pop;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_v = 0; m_dir = 1'b1;
    m_alive = 1'b0; m_frozen = 1'b0; m_pop = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit s, input bit p, input bit h,
                            input int ix, input int iy, input bit d);
    int nx, ny, nv;
    if (m_pop) begin
      m_pop = 1'b0;
    end else if (!m_alive) begin
      if (l) begin
        m_x = ix * 64; m_y = iy * 64; m_v = 0; m_dir = d;
        m_alive = 1'b1; m_frozen = 1'b0;
      end
    end else if (h) begin
      m_alive = 1'b0; m_pop = 1'b1;
    end else if (m_frozen) begin
      if (!p) m_frozen = 1'b0;
    end else if (p) begin
      m_frozen = 1'b1;
    end else if (s) begin
      nv = (m_v + 8 > 512) ? 512 : m_v + 8;
      ny = m_y + nv;
      nx = m_x + (m_dir ? 64 : -64);
      if (nx < 0) begin
        nx = 0; m_dir = 1'b1;
      end else if (nx > 614 * 64) begin
        nx = 614 * 64; m_dir = 1'b0;
      end
      if (ny > 414 * 64 && nv > 0) begin
        ny = 414 * 64; nv = -384;
      end else if (ny < 0) begin
        ny = 0; nv = 0;
      end
      m_x = nx; m_y = ny; m_v = nv;
    end
  endtask

  task automatic cmp(input string name, input int ex, input int ey, input bit ev, input bit ep);
    logic [10:0] wx, wy;
    wx = ex[10:0];
    wy = ey[10:0];
    vectors++;
    if (topLeftX !== wx || topLeftY !== wy || visible !== ev || popped !== ep) begin
      miscompares++;
      $display("FAIL %s @%0t: got x=%0d y=%0d vis=%0b pop=%0b, want x=%0d y=%0d vis=%0b pop=%0b",
               name, $time, topLeftX, topLeftY, visible, popped, wx, wy, ev, ep);
    end
  endtask

  task automatic step(input bit l, input bit s, input bit p, input bit h,
                      input int ix, input int iy, input bit d);
    launch = l; startOfFrame = s; pause = p; hitRope = h;
    initX = ix[10:0]; initY = iy[10:0]; dirRight = d;
    @(posedge clk);
    model_step(l, s, p, h, ix, iy, d);
    #1;
    cmp("model", m_x / 64, m_y / 64, m_alive, m_pop);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  typedef struct {
    bit l, s, p, h;
    int ix, iy;
    bit d;
    int ex, ey;
    bit ev, ep;
  } vec_t;

  function automatic vec_t mk(bit l, bit s, bit p, bit h, int ix, int iy, bit d,
                              int ex, int ey, bit ev, bit ep);
    vec_t v;
    v.l = l; v.s = s; v.p = p; v.h = h; v.ix = ix; v.iy = iy; v.d = d;
    v.ex = ex; v.ey = ey; v.ev = ev; v.ep = ep;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit p_level, l, s, h, d;
    int ix, iy;

    //         l  s  p  h   ix   iy  d    ex   ey  vis pop
    tbl.push_back(mk(1, 0, 0, 0, 613, 100, 1,  613, 100, 1, 0)); // right wall approach
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  614, 100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  614, 100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  613, 100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1,   0,   0, 0,  613, 100, 0, 1)); // hit wins over frame
    tbl.push_back(mk(0, 0, 0, 1,   0,   0, 0,  613, 100, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,   0,   0, 0,  613, 100, 0, 0)); // hit in IDLE ignored
    tbl.push_back(mk(1, 0, 0, 0, 200, 200, 0,  200, 200, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  199, 200, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,   5,   5, 1,  198, 200, 1, 0)); // launch while moving ignored
    tbl.push_back(mk(0, 0, 1, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,  198, 200, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  197, 200, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,  196, 201, 1, 0)); // speed resumed at 32
    tbl.push_back(mk(0, 0, 1, 1,   0,   0, 0,  196, 201, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,  196, 201, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   0,  10, 0,    0,  10, 1, 0)); // left wall
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,    0,  10, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0,   0, 0,    1,  10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,   0,   0, 0,    1,  10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0,    1,  10, 0, 0));

    reset = 1'b1;
    launch = 1'b0; startOfFrame = 1'b0; pause = 1'b0; hitRope = 1'b0;
    initX = '0; initY = '0; dirRight = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_init", 0, 0, 1'b0, 1'b0);
    #2 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].h, tbl[i].ix, tbl[i].iy, tbl[i].d);
      cmp($sformatf("table[%0d]", i), tbl[i].ex, tbl[i].ey, tbl[i].ev, tbl[i].ep);
    end

    // Eight frames of free flight from (100,50) moving right.
    step(1'b1, 1'b0, 1'b0, 1'b0, 100, 50, 1'b1);
    for (int f = 0; f < 8; f++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle_step();
    end
    cmp("flight_8", 108, 54, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cmp("flight_9", 109, 55, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    idle_step();

    // Floor bounce from a spawn on the floor line.
    step(1'b1, 1'b0, 1'b0, 1'b0, 300, 414, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cmp("floor_1", 301, 414, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cmp("floor_2", 302, 408, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle while moving.
    #4 reset = 1'b1;
    #1;
    cmp("reset_async", 0, 0, 1'b0, 1'b0);
    model_reset();
    #1 reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cmp("reset_frame_no_launch", 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10, 20, 1'b0);
    cmp("relaunch", 10, 20, 1'b1, 1'b0);

    p_level = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (p_level) p_level = ($urandom_range(0, 3) != 0);
      else         p_level = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 79) == 0);
      d  = ($urandom_range(0, 1) == 1);
      ix = int'($urandom_range(0, 640));
      iy = int'($urandom_range(0, 470));
      step(l, s, p_level, h, ix, iy, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_move.md
BALL_MOVE -- requirements
Module: ball_move

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port startOfFrame, input, 1, one-cycle pulse per video frame.
REQ-004 SHALL have port launch, input, 1, one-cycle pulse that starts a ball.
REQ-005 SHALL have ports initX and initY, input, 11 each, spawn top-left pixel position, sampled on launch.
REQ-006 SHALL have port dirRight, input, 1, initial horizontal direction, sampled on launch (1=right).
REQ-007 SHALL have port pause, input, 1, level; freezes motion while high.
REQ-008 SHALL have port hitRope, input, 1, one-cycle pulse meaning rope collision with this ball.
REQ-009 SHALL have ports topLeftX and topLeftY, output, 11 each, integer pixel position of the ball for the rectangle/bitmap stage.
REQ-010 SHALL have port visible, output, 1, high while the ball exists; drives the bitmap visible input.
REQ-011 SHALL have port popped, output, 1, one-cycle pulse on pop.

Function
REQ-012 SHALL hold position internally as signed 18-bit fixed point, 6 fraction bits (1 px = 64); topLeftX/Y = position arithmetic-shifted right 6, truncated.
REQ-013 SHALL implement states IDLE, MOVING, PAUSED, POPPED.
REQ-014 IDLE: visible=0; launch loads posX=initX*64, posY=initY*64, ySpeed=0, xDir=dirRight, then enters MOVING next cycle.
REQ-015 MOVING: on startOfFrame, ySpeed_new = min(ySpeed+GRAVITY, MAX_Y_SPEED); posY_new = posY+ySpeed_new; posX_new = posX ± X_SPEED per xDir; all registered in the same edge.
REQ-016 Constants: GRAVITY=8, MAX_Y_SPEED=512, X_SPEED=64, BOUNCE_SPEED=384, X_MAX=614 px, Y_FLOOR=414 px (640x480 screen, 26x26 ball).
REQ-017 Left wall: posX_new<0 -> posX=0, xDir=right; right wall: posX_new>X_MAX*64 -> posX=X_MAX*64, xDir=left.
REQ-018 Floor: posY_new>Y_FLOOR*64 with ySpeed_new>0 -> posY=Y_FLOOR*64, ySpeed=-BOUNCE_SPEED.
REQ-019 Ceiling: posY_new<0 -> posY=0, ySpeed=0.
REQ-020 pause high in MOVING -> PAUSED; pause low in PAUSED -> MOVING; PAUSED ignores startOfFrame, keeps visible=1.
REQ-021 hitRope in MOVING or PAUSED -> POPPED; it wins over a coincident startOfFrame (no motion applied that cycle).
REQ-022 POPPED: visible=0, popped=1 for exactly one cycle, then IDLE.
REQ-023 launch outside IDLE SHALL be ignored; hitRope in IDLE/POPPED SHALL be ignored.
REQ-024 Outputs SHALL be registered; the new position appears one cycle after the startOfFrame edge, before the first active pixel.

Reset
REQ-025 reset SHALL force IDLE, posX=posY=0, ySpeed=0, xDir=right, topLeftX=topLeftY=0, visible=0, popped=0, immediately and regardless of state, mid-frame included.
REQ-026 After reset release, first legal action SHALL be launch.

Structure
REQ-027 State enum and all REQ-016 constants plus fraction-bit count SHALL live in shared package ball_pkg.
REQ-028 No sub-module; a single module with one state register and one next-state/motion process.

Verification
REQ-029 Reset mid-MOVING -> next edge visible=0, topLeftX=topLeftY=0, state IDLE.
REQ-030 launch initX=100, initY=50, dirRight=1, then 8 startOfFrame pulses -> topLeftX=108, topLeftY=54, ySpeed=64.
REQ-031 launch initX=613, dirRight=1; frames 1,2,3 -> topLeftX 614, 614 (xDir flips left), 613.
REQ-032 launch initY=414; frame 1 -> topLeftY=414, ySpeed=-384; frame 2 -> ySpeed=-376, topLeftY=408.
REQ-033 hitRope coincident with startOfFrame in MOVING -> position unchanged, next cycle popped=1 and visible=0, following cycle popped=0, state IDLE.
REQ-034 pause held across 3 frames -> topLeftX/Y constant, visible=1; after release, next frame resumes from frozen ySpeed.
